// File: rtl/data_mem_tracer.sv
// data_mem_tracer
//   Data-memory responder for the single-cycle MIPS core. It applies
//   byte/half/word stores with per-byte little-endian lanes and returns the
//   addressed word combinationally. Every accepted store is also queued in a
//   show-ahead trace FIFO that a host can drain with a valid/ready handshake.
//
// Ports
//   clk            : single clock, rising-edge state updates
//   reset          : asynchronous active-high; clears FIFO, counters, error flag
//   memwrite[1:0]  : store size, 00 none / 01 sb / 10 sh / 11 sw
//   dataadr[31:0]  : byte address of the access
//   writedata[31:0]: right-aligned store data
//   readdata[31:0] : stored word at dataadr, unshifted
//   trace_valid    : FIFO holds at least one entry
//   trace_ready    : consumer pops the head when both are high at an edge
//   trace_addr/data/size : head entry, zero while the FIFO is empty
//   overflow_count : stores dropped from the trace, saturating at 255
//   misalign_err   : sticky flag for a rejected misaligned store
module data_mem_tracer #(
  parameter int AW    = 6,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [1:0]  trace_size,
  output logic [7:0]  overflow_count,
  output logic        misalign_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [31:0] mem [2**AW];

  logic [31:0] fifo_addr [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [1:0]  fifo_size [DEPTH];

  logic [AW-1:0] word_idx;
  logic [3:0]    byte_en;
  logic [31:0]   lane_data;
  logic [31:0]   masked_data;
  logic          misaligned;
  logic          accept;

  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Address bits above the memory size are deliberately ignored (wrap-around).
  logic unused_addr;
  assign unused_addr = ^dataadr[31:AW+2];

  assign word_idx = dataadr[AW+1:2];
  assign readdata = mem[word_idx];

  // Decode the store size into lane enables, lane-replicated write data
  // (so any enabled lane picks the right bytes) and the zero-extended value
  // recorded in the trace.
  always_comb begin
    byte_en     = 4'b0000;
    lane_data   = 32'd0;
    masked_data = 32'd0;
    misaligned  = 1'b0;
    case (memwrite)
      2'b01: begin
        byte_en     = 4'b0001 << dataadr[1:0];
        lane_data   = {4{writedata[7:0]}};
        masked_data = {24'd0, writedata[7:0]};
      end
      2'b10: begin
        misaligned  = dataadr[0];
        byte_en     = dataadr[1] ? 4'b1100 : 4'b0011;
        lane_data   = {2{writedata[15:0]}};
        masked_data = {16'd0, writedata[15:0]};
      end
      2'b11: begin
        misaligned  = |dataadr[1:0];
        byte_en     = 4'b1111;
        lane_data   = writedata;
        masked_data = writedata;
      end
      default: ;
    endcase
  end

  // Stores are gated by reset so nothing lands while reset is held.
  assign accept = (memwrite != 2'b00) && !misaligned && !reset;

  // Memory array is intentionally not reset; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

  // One extra pointer bit separates full from empty when indices match.
  assign trace_valid = (wr_ptr != rd_ptr);
  assign full        = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop         = trace_valid && trace_ready;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the tail index points at, so the push can proceed.
  assign push        = accept && (!full || pop);
  assign drop        = accept && full && !pop;

  // Trace payload storage; stale slots are masked off at the head output.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= dataadr;
      fifo_data[wr_ptr[PW-1:0]] <= masked_data;
      fifo_size[wr_ptr[PW-1:0]] <= memwrite;
    end
  end

  // Pointers, drop counter and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      overflow_count <= 8'd0;
      misalign_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop && (overflow_count != 8'hFF)) overflow_count <= overflow_count + 8'd1;
      if (misaligned) misalign_err <= 1'b1;
    end
  end

  // Show-ahead head, forced to zero when nothing is queued.
  assign trace_addr = trace_valid ? fifo_addr[rd_ptr[PW-1:0]] : 32'd0;
  assign trace_data = trace_valid ? fifo_data[rd_ptr[PW-1:0]] : 32'd0;
  assign trace_size = trace_valid ? fifo_size[rd_ptr[PW-1:0]] : 2'd0;

endmodule

// File: tb/tb_data_mem_tracer.sv
// tb_data_mem_tracer
//   Directed bench for data_mem_tracer: word/byte/half stores, lane merging,
//   misalignment rejection, trace ordering, overflow/saturation, full-FIFO
//   push+pop and asynchronous reset in mid-operation.
module tb_data_mem_tracer;

  logic        clk;
  logic        reset;
  logic [1:0]  memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [1:0]  trace_size;
  logic [7:0]  overflow_count;
  logic        misalign_err;

  int tests_run;
  int tests_failed;

  data_mem_tracer #(.AW(6), .DEPTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .memwrite       (memwrite),
    .dataadr        (dataadr),
    .writedata      (writedata),
    .readdata       (readdata),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_size     (trace_size),
    .overflow_count (overflow_count),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] data);
    memwrite  = size;
    dataadr   = addr;
    writedata = data;
    step();
    memwrite  = 2'b00;
  endtask

  task automatic look(input logic [31:0] addr);
    memwrite = 2'b00;
    dataadr  = addr;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; memwrite = 2'b00; dataadr = 32'd0; writedata = 32'd0;
    trace_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #2;
    tests_run++;
    if (trace_valid !== 1'b0 || trace_addr !== 32'd0 || trace_data !== 32'd0 ||
        trace_size !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_head: got v=%0b a=%h d=%h s=%0d expected all 0",
               trace_valid, trace_addr, trace_data, trace_size);
    end
    tests_run++;
    if (overflow_count !== 8'd0 || misalign_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got ovf=%0d err=%0b expected 0 0",
               overflow_count, misalign_err);
    end
  endtask

  task automatic test_word_store();
    step();
    store(2'b11, 32'd84, 32'hFFFF7F02);
    look(32'd84);
    tests_run++;
    if (readdata !== 32'hFFFF7F02) begin
      tests_failed++;
      $display("[TB] FAIL sw_read: got %h expected FFFF7F02", readdata);
    end
    tests_run++;
    if (trace_valid !== 1'b1 || trace_addr !== 32'd84 ||
        trace_data !== 32'hFFFF7F02 || trace_size !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL sw_trace: got v=%0b a=%0d d=%h s=%0d expected 1 84 FFFF7F02 3",
               trace_valid, trace_addr, trace_data, trace_size);
    end
    trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    tests_run++;
    if (trace_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sw_pop: got valid=%0b expected 0", trace_valid);
    end
  endtask

  task automatic test_byte_half();
    // Upper garbage in writedata must be ignored by both memory and trace.
    memwrite = 2'b01; dataadr = 32'd85; writedata = 32'hDEADBEAB;
    #1;
    tests_run++;
    if (readdata !== 32'hFFFF7F02) begin
      tests_failed++;
      $display("[TB] FAIL no_write_through: got %h expected FFFF7F02", readdata);
    end
    step();
    memwrite = 2'b00;
    store(2'b10, 32'd86, 32'hCAFE1234);
    look(32'd84);
    tests_run++;
    if (readdata !== 32'h1234AB02) begin
      tests_failed++;
      $display("[TB] FAIL lanes_read: got %h expected 1234AB02", readdata);
    end
    tests_run++;
    if (trace_addr !== 32'd85 || trace_data !== 32'h000000AB || trace_size !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL sb_trace: got a=%0d d=%h s=%0d expected 85 000000AB 1",
               trace_addr, trace_data, trace_size);
    end
    trace_ready = 1'b1;
    step();
    tests_run++;
    if (trace_valid !== 1'b1 || trace_addr !== 32'd86 ||
        trace_data !== 32'h00001234 || trace_size !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL sh_trace: got v=%0b a=%0d d=%h s=%0d expected 1 86 00001234 2",
               trace_valid, trace_addr, trace_data, trace_size);
    end
    step();
    trace_ready = 1'b0;
    tests_run++;
    if (trace_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lanes_empty: got valid=%0b expected 0", trace_valid);
    end
  endtask

  task automatic test_misaligned();
    store(2'b10, 32'd87, 32'h0000FFFF);
    store(2'b11, 32'd86, 32'hFFFFFFFF);
    look(32'd84);
    tests_run++;
    if (readdata !== 32'h1234AB02) begin
      tests_failed++;
      $display("[TB] FAIL misalign_mem: got %h expected 1234AB02", readdata);
    end
    tests_run++;
    if (misalign_err !== 1'b1 || trace_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL misalign_flag: got err=%0b valid=%0b expected 1 0",
               misalign_err, trace_valid);
    end
  endtask

  task automatic test_wrap_and_sb_lane3();
    // 84 + 256 aliases word 21; sb to lane 3 needs no alignment.
    store(2'b11, 32'd340, 32'h11223344);
    store(2'b01, 32'd87, 32'h00000099);
    look(32'd84);
    tests_run++;
    if (readdata !== 32'h99223344) begin
      tests_failed++;
      $display("[TB] FAIL wrap_read: got %h expected 99223344", readdata);
    end
    tests_run++;
    if (trace_addr !== 32'd340 || trace_data !== 32'h11223344) begin
      tests_failed++;
      $display("[TB] FAIL wrap_trace: got a=%0d d=%h expected 340 11223344",
               trace_addr, trace_data);
    end
    trace_ready = 1'b1;
    step(); step();
    trace_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) store(2'b11, 32'(4 * i), 32'(i));
    tests_run++;
    if (overflow_count !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL ovf_count: got %0d expected 2", overflow_count);
    end
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (trace_valid !== 1'b1 || trace_addr !== 32'(4 * i)) begin
        tests_failed++;
        $display("[TB] FAIL ovf_drain%0d: got v=%0b a=%0d expected 1 %0d",
                 i, trace_valid, trace_addr, 4 * i);
      end
      step();
    end
    trace_ready = 1'b0;
    tests_run++;
    if (trace_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_empty: got valid=%0b expected 0", trace_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) store(2'b11, 32'(64 + 4 * i), 32'(i));
    memwrite = 2'b11; dataadr = 32'd128; writedata = 32'h80; trace_ready = 1'b1;
    step();
    memwrite = 2'b00; trace_ready = 1'b0;
    tests_run++;
    if (overflow_count !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL full_pushpop_ovf: got %0d expected 2", overflow_count);
    end
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (trace_valid !== 1'b1 || trace_addr !== ((i == 7) ? 32'd128 : 32'(68 + 4 * i))) begin
        tests_failed++;
        $display("[TB] FAIL full_drain%0d: got v=%0b a=%0d expected 1 %0d",
                 i, trace_valid, trace_addr, (i == 7) ? 128 : 68 + 4 * i);
      end
      step();
    end
    trace_ready = 1'b0;
    tests_run++;
    if (trace_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_empty: got valid=%0b expected 0", trace_valid);
    end
  endtask

  task automatic test_saturation();
    // 8 fill the FIFO, 300 more are dropped on top of the 2 already counted.
    for (int i = 0; i < 308; i++) store(2'b11, 32'd0, 32'(i));
    tests_run++;
    if (overflow_count !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL ovf_saturate: got %0d expected 255", overflow_count);
    end
  endtask

  task automatic test_reset_mid();
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    trace_ready = 1'b0;
    store(2'b11, 32'd84, 32'h5A5AC3C3);
    store(2'b11, 32'd88, 32'h1);
    store(2'b11, 32'd92, 32'h2);
    tests_run++;
    if (trace_valid !== 1'b1 || misalign_err !== 1'b1 || overflow_count !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset: got v=%0b err=%0b ovf=%0d expected 1 1 255",
               trace_valid, misalign_err, overflow_count);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (trace_valid !== 1'b0 || overflow_count !== 8'd0 || misalign_err !== 1'b0 ||
        trace_addr !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got v=%0b ovf=%0d err=%0b a=%h expected 0 0 0 0",
               trace_valid, overflow_count, misalign_err, trace_addr);
    end
    memwrite = 2'b11; dataadr = 32'd84; writedata = 32'h0BADBAD0;
    step(); step();
    memwrite = 2'b00;
    #2 reset = 1'b0;
    look(32'd84);
    tests_run++;
    if (readdata !== 32'h5A5AC3C3) begin
      tests_failed++;
      $display("[TB] FAIL reset_mem_kept: got %h expected 5A5AC3C3", readdata);
    end
    step();
    tests_run++;
    if (trace_valid !== 1'b0 || misalign_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_store_gated: got v=%0b err=%0b expected 0 0",
               trace_valid, misalign_err);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_word_store();
    test_byte_half();
    test_misaligned();
    test_wrap_and_sb_lane3();
    test_overflow();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
